// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Instruction-fetch sequencer for the single-issue MIPS datapath. It owns the
//   program counter and fetches one instruction at a time over a req/ack
//   handshake with instruction memory. Each instruction goes to decode over a
//   valid/ready handshake. When decode accepts, the next PC is chosen from the
//   jump-register, jump, branch or sequential target.
//
//   Build option: define PC_SEQ_JR_EN to honour jump_reg/rs_value.
//   When PC_SEQ_JR_EN is undefined:
//     - jump_reg and rs_value are ignored.
//     - misalign_err stays 0.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   MAX_WAIT     fetch cycles without ack before timeout (2..255)
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and address (address == pc)
//   imem_ack/imem_rdata instruction memory response
//   instr_out/pc_out    registered instruction and its PC for decode
//   instr_valid         instr_out valid (DECODE state)
//   instr_ready         decode accept / stall (low = stall)
//   branch_taken, jump, jump_reg, rs_value
//                       next-PC controls, sampled only at accept
//   retired             count of accepted instructions (wraps)
//   timeout_err         sticky fetch-timeout flag
//   misalign_err        sticky misaligned jump-register target flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_value,
    output logic [31:0] retired,
    output logic        timeout_err,
    output logic        misalign_err
);

    // ST_DROP is the single dead cycle after a timeout. The request is low
    // in that cycle, and an ack arriving then is ignored.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DROP   = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_out_q,   pc_out_d;
    logic [31:0] retired_q,  retired_d;
    logic [7:0]  wait_q,     wait_d;
    logic        timeout_q,  timeout_d;
    logic        misalign_q, misalign_d;

    logic [31:0] p4_s;
    logic [31:0] next_pc_s;
    logic        jr_sel_s;
    logic        jr_misalign_s;

`ifdef PC_SEQ_JR_EN
    assign jr_sel_s      = jump_reg;
    assign jr_misalign_s = jump_reg && (rs_value[1:0] != 2'b00);
`else
    logic unused_jr_s;
    assign unused_jr_s   = ^{jump_reg, rs_value};
    assign jr_sel_s      = 1'b0;
    assign jr_misalign_s = 1'b0;
`endif

    // Next-PC selection from the accepted instruction; the first match wins.
    always_comb begin
        p4_s = pc_out_q + 32'd4;
        if (jr_sel_s) begin
            next_pc_s = {rs_value[31:2], 2'b00};
        end else if (jump) begin
            next_pc_s = {p4_s[31:28], instr_q[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc_s = p4_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end else begin
            next_pc_s = p4_s;
        end
    end

    // Fetch/decode state machine next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        retired_d  = retired_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    wait_d   = 8'd0;
                    state_d  = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    wait_d    = 8'd0;
                    state_d   = ST_DROP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DROP: begin
                state_d = ST_FETCH;
            end
            ST_DECODE: begin
                if (instr_ready) begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc_s;
                    state_d   = ST_FETCH;
                    if (jr_misalign_s) begin
                        misalign_d = 1'b1;
                    end else begin
                        misalign_d = misalign_q;
                    end
                end else begin
                    state_d = ST_DECODE;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_out_q   <= 32'd0;
            retired_q  <= 32'd0;
            wait_q     <= 8'd0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            retired_q  <= retired_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == ST_DECODE);
    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign retired      = retired_q;
    assign timeout_err  = timeout_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. It uses directed scenarios plus a
//   randomized run. A transaction-level reference model tracks:
//     - the fetch / dead / present phase
//     - the PC
//     - the retired count
//     - the sticky flags
//   The model's PC targets are computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h1000_0000;
    localparam int          MW     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] rs_value;
    logic [31:0] retired;
    logic        timeout_err;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    // m_phase: 0 = requesting, 1 = dead cycle after timeout,
    //          2 = presenting to decode.
    int          m_phase;
    int          m_waited;
    logic [31:0] m_pc, m_instr, m_pcout, m_ret;
    logic        m_terr, m_merr;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_taken(branch_taken), .jump(jump),
        .jump_reg(jump_reg), .rs_value(rs_value), .retired(retired),
        .timeout_err(timeout_err), .misalign_err(misalign_err)
    );

    function automatic logic [31:0] model_target();
        logic [31:0] p4;
        int          off;
        p4 = m_pcout + 32'd4;
`ifdef PC_SEQ_JR_EN
        if (jump_reg) return rs_value & 32'hFFFF_FFFC;
`endif
        if (jump) return (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
        if (branch_taken) begin
            off = int'($signed(m_instr[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    // Advance the model using the inputs the DUT samples at the next edge.
    // Then move to just after that edge.
    task automatic step();
        if (reset) begin
            m_phase = 0; m_waited = 0; m_pc = RST_PC; m_instr = 32'd0;
            m_pcout = 32'd0; m_ret = 32'd0; m_terr = 1'b0; m_merr = 1'b0;
        end else if (m_phase == 0) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_pcout = m_pc; m_waited = 0; m_phase = 2;
            end else if (m_waited + 1 == MW) begin
                m_terr = 1'b1; m_waited = 0; m_phase = 1;
            end else begin
                m_waited++;
            end
        end else if (m_phase == 1) begin
            m_phase = 0;
        end else if (instr_ready) begin
`ifdef PC_SEQ_JR_EN
            if (jump_reg && rs_value[1:0] != 2'b00) m_merr = 1'b1;
`endif
            m_ret   = m_ret + 32'd1;
            m_pc    = model_target();
            m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; rs_value = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Fetch one instruction (ack in first fetch cycle), accept it with controls.
    task automatic deliver(input logic [31:0] ins, input logic br, input logic j,
                           input logic jr, input logic [31:0] rs);
        imem_ack = 1'b1; imem_rdata = ins;
        step();
        imem_ack = 1'b0;
        instr_ready = 1'b1; branch_taken = br; jump = j; jump_reg = jr; rs_value = rs;
        step();
        instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if ({instr_out, pc_out, retired} !== 96'd0) begin bad++; $display("FAIL rst_regs got=%h/%h/%h exp=0", instr_out, pc_out, retired); end
        total++; if ({timeout_err, misalign_err} !== 2'b00) begin bad++; $display("FAIL rst_errs got=%b%b exp=00", timeout_err, misalign_err); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_addr !== RST_PC + 32'(4 * i) || imem_req !== 1'b1) begin
                bad++; $display("FAIL seq_addr%0d got=%h req=%b exp=%h", i, imem_addr, imem_req, RST_PC + 32'(4 * i));
            end
            imem_ack = 1'b1; imem_rdata = $urandom;
            step();
            imem_ack = 1'b0;
            total++; if (instr_valid !== 1'b1 || pc_out !== RST_PC + 32'(4 * i)) begin
                bad++; $display("FAIL seq_valid%0d got=%b pc_out=%h", i, instr_valid, pc_out);
            end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end
        total++; if (retired !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_jump_branch();
        do_reset();
        deliver(32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'd0);
        total++; if (imem_addr !== 32'h1000_0100) begin bad++; $display("FAIL jump_addr got=%h exp=10000100", imem_addr); end
        deliver(32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'd0);
        total++; if (imem_addr !== 32'h1000_0100) begin bad++; $display("FAIL branch_back got=%h exp=10000100", imem_addr); end
        deliver(32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 32'd0);
        total++; if (imem_addr !== 32'h1003_FFFC) begin bad++; $display("FAIL jump_over_branch got=%h exp=1003fffc", imem_addr); end
    endtask

    task automatic test_jump_reg();
        logic [31:0] exp_addr;
        logic        exp_merr;
`ifdef PC_SEQ_JR_EN
        exp_addr = 32'h0000_2000; exp_merr = 1'b1;
`else
        exp_addr = RST_PC + 32'd4; exp_merr = 1'b0;
`endif
        do_reset();
        deliver(32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_2003);
        total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL jr_addr got=%h exp=%h", imem_addr, exp_addr); end
        total++; if (misalign_err !== exp_merr) begin bad++; $display("FAIL jr_misalign got=%b exp=%b", misalign_err, exp_merr); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < MW; i++) begin
            total++; if (imem_req !== 1'b1 || timeout_err !== 1'b0) begin
                bad++; $display("FAIL to_wait%0d got req=%b err=%b exp req=1 err=0", i, imem_req, timeout_err);
            end
            step();
        end
        total++; if (imem_req !== 1'b0 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_drop got req=%b err=%b exp req=0 err=1", imem_req, timeout_err);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
            bad++; $display("FAIL to_rereq got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, RST_PC);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_complete got valid=%b instr=%h err=%b", instr_valid, instr_out, timeout_err);
        end
    endtask

    task automatic test_stall_reset();
        logic [31:0] ins;
        do_reset();
        deliver(32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd0);
        ins = $urandom;
        imem_ack = 1'b1; imem_rdata = ins;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (instr_out !== ins || retired !== 32'd1 || instr_valid !== 1'b1) begin
                bad++; $display("FAIL stall%0d got instr=%h ret=%0d valid=%b exp instr=%h ret=1 valid=1", i, instr_out, retired, instr_valid, ins);
            end
            jump = 1'(($urandom) & 1); branch_taken = 1'(($urandom) & 1);
            step();
        end
        jump = 1'b0; branch_taken = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0 ||
                     instr_out !== 32'd0 || pc_out !== 32'd0 || retired !== 32'd0) begin
            bad++; $display("FAIL stall_reset got req=%b addr=%h valid=%b instr=%h pc_out=%h ret=%0d", imem_req, imem_addr, instr_valid, instr_out, pc_out, retired);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            imem_ack     = ($urandom_range(0, 2) == 0);
            imem_rdata   = $urandom;
            instr_ready  = 1'($urandom & 1);
            branch_taken = 1'($urandom & 1);
            jump         = ($urandom_range(0, 3) == 0);
            jump_reg     = ($urandom_range(0, 5) == 0);
            rs_value     = $urandom;
            step();
            total++; if (imem_req !== (m_phase == 0)) begin bad++; $display("FAIL rnd_req c=%0d got=%b", c, imem_req); end
            total++; if (instr_valid !== (m_phase == 2)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b", c, instr_valid); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_pc); end
            total++; if (instr_out !== m_instr) begin bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, instr_out, m_instr); end
            total++; if (pc_out !== m_pcout) begin bad++; $display("FAIL rnd_pc_out c=%0d got=%h exp=%h", c, pc_out, m_pcout); end
            total++; if (retired !== m_ret) begin bad++; $display("FAIL rnd_retired c=%0d got=%0d exp=%0d", c, retired, m_ret); end
            total++; if (timeout_err !== m_terr) begin bad++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, timeout_err, m_terr); end
            total++; if (misalign_err !== m_merr) begin bad++; $display("FAIL rnd_misalign c=%0d got=%b exp=%b", c, misalign_err, m_merr); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_phase = 0; m_waited = 0; m_pc = RST_PC; m_instr = 32'd0;
        m_pcout = 32'd0; m_ret = 32'd0; m_terr = 1'b0; m_merr = 1'b0;
        test_reset();
        test_sequential();
        test_jump_branch();
        test_jump_reg();
        test_timeout();
        test_stall_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
